// File: rtl/fpu_pkg.sv
// Shared FPU definitions: RISC-V FCLASS bit positions, binary-format presets
// and the classification flag bundle carried down the unpack pipeline.
package fpu_pkg;

  localparam int CLS_W        = 10;
  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;

  localparam int HALF_EXP_W    = 5;
  localparam int HALF_FRAC_W   = 10;
  localparam int SINGLE_EXP_W  = 8;
  localparam int SINGLE_FRAC_W = 23;
  localparam int DOUBLE_EXP_W  = 11;
  localparam int DOUBLE_FRAC_W = 52;

  typedef struct packed {
    logic zero;
    logic sub;
    logic inf;
    logic nan;
    logic snan;
  } fpFlags_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 23
) (
  input  logic [WIDTH-1:0]             value,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int CW = $clog2(WIDTH+1);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_unpack_pipe.sv
// Two-stage IEEE-754 operand unpacker: sign, unbiased exponent, normalised
// significand, FCLASS mask and special-case flags, with valid/ready flow control.
// Build option: FPU_UNPACK_DAZ_EN flushes subnormal inputs to signed zero.
module fpu_unpack_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [EXP_W+FRAC_W:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  sign_o,
  output logic [EXP_W+1:0]      exp_o,
  output logic [FRAC_W:0]       sig_o,
  output logic [CLS_W-1:0]      class_o,
  output logic                  is_zero_o,
  output logic                  is_subnormal_o,
  output logic                  is_inf_o,
  output logic                  is_nan_o,
  output logic                  is_snan_o
);

  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int DW   = 1 + EXP_W + FRAC_W;
  localparam int EW   = EXP_W + 2;

  logic              vld_p1, vld_p2;
  logic              s2Load, inReady;
  logic              signIn;
  logic [EXP_W-1:0]  expFldIn;
  logic [FRAC_W-1:0] fracIn;
  logic              isMaxExp, isZeroExp, isZeroFrac;
  fpFlags_t          flagsIn;

  logic              sign_p1;
  logic [EXP_W-1:0]  expFld_p1;
  logic [FRAC_W-1:0] frac_p1;
  fpFlags_t          flags_p1;

  logic [EW-1:0]     expC;
  logic [FRAC_W:0]   sigC;
  logic [CLS_W-1:0]  clsC;
  int                expVal;

  logic              sign_p2;
  logic [EW-1:0]     exp_p2;
  logic [FRAC_W:0]   sig_p2;
  logic [CLS_W-1:0]  cls_p2;
  fpFlags_t          flags_p2;

  // A stage accepts new content when empty or when its content leaves this cycle.
  assign s2Load     = !vld_p2 || out_ready_i;
  assign inReady    = !vld_p1 || s2Load;
  assign in_ready_o = inReady;

  // ---- stage 1: field split and classification ----
  assign signIn     = in_data_i[DW-1];
  assign expFldIn   = in_data_i[DW-2 -: EXP_W];
  assign fracIn     = in_data_i[FRAC_W-1:0];
  assign isMaxExp   = &expFldIn;
  assign isZeroExp  = ~|expFldIn;
  assign isZeroFrac = ~|fracIn;

`ifdef FPU_UNPACK_DAZ_EN
  assign flagsIn.zero = isZeroExp;
  assign flagsIn.sub  = 1'b0;
`else
  logic [$clog2(FRAC_W+1)-1:0] lzIn, lz_p1;

  fpu_lzc #(.WIDTH(FRAC_W)) uLzc (
    .value (fracIn),
    .count (lzIn)
  );

  assign flagsIn.zero = isZeroExp && isZeroFrac;
  assign flagsIn.sub  = isZeroExp && !isZeroFrac;
`endif
  assign flagsIn.inf  = isMaxExp && isZeroFrac;
  assign flagsIn.nan  = isMaxExp && !isZeroFrac;
  assign flagsIn.snan = isMaxExp && !isZeroFrac && !fracIn[FRAC_W-1];

  // Stage-1 occupancy; cleared by reset so in-flight operands are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i)      vld_p1 <= 1'b0;
    else if (inReady) vld_p1 <= in_valid_i;
  end

  // Stage-1 data captured only on an accepted transfer.
  always_ff @(posedge clk_i) begin
    if (inReady && in_valid_i) begin
      sign_p1   <= signIn;
      expFld_p1 <= expFldIn;
      frac_p1   <= fracIn;
      flags_p1  <= flagsIn;
`ifndef FPU_UNPACK_DAZ_EN
      lz_p1     <= lzIn;
`endif
    end
  end

  // ---- stage 2: exponent/significand normalisation and FCLASS ----
  // Specials take priority; subnormals are shifted until the hidden bit is set.
  always_comb begin
    expVal = 0;
    expC   = '0;
    sigC   = '0;
    clsC   = '0;
    if (flags_p1.nan) begin
      expVal = BIAS + 1;
      sigC   = {1'b1, frac_p1};
      clsC[flags_p1.snan ? CLS_SNAN : CLS_QNAN] = 1'b1;
    end else if (flags_p1.inf) begin
      expVal = BIAS + 1;
      sigC   = {1'b1, frac_p1};
      clsC[sign_p1 ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
    end else if (flags_p1.zero) begin
      clsC[sign_p1 ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
`ifndef FPU_UNPACK_DAZ_EN
    end else if (flags_p1.sub) begin
      expVal = 1 - BIAS - (int'(lz_p1) + 1);
      sigC   = {1'b0, frac_p1} << (int'(lz_p1) + 1);
      clsC[sign_p1 ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
`endif
    end else begin
      expVal = int'(expFld_p1) - BIAS;
      sigC   = {1'b1, frac_p1};
      clsC[sign_p1 ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
    end
    expC = EW'(expVal);
  end

  // Output-stage occupancy; holds while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i)     vld_p2 <= 1'b0;
    else if (s2Load) vld_p2 <= vld_p1;
  end

  // Output data registers; zero out of reset, frozen while stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sign_p2  <= 1'b0;
      exp_p2   <= '0;
      sig_p2   <= '0;
      cls_p2   <= '0;
      flags_p2 <= '0;
    end else if (s2Load && vld_p1) begin
      sign_p2  <= sign_p1;
      exp_p2   <= expC;
      sig_p2   <= sigC;
      cls_p2   <= clsC;
      flags_p2 <= flags_p1;
    end
  end

  assign out_valid_o    = vld_p2;
  assign sign_o         = sign_p2;
  assign exp_o          = exp_p2;
  assign sig_o          = sig_p2;
  assign class_o        = cls_p2;
  assign is_zero_o      = flags_p2.zero;
  assign is_subnormal_o = flags_p2.sub;
  assign is_inf_o       = flags_p2.inf;
  assign is_nan_o       = flags_p2.nan;
  assign is_snan_o      = flags_p2.snan;

endmodule
